// File: rtl/regfile_access_seq_pkg.sv
// Shared types and default sizes for the register-file access sequencer.
package regfile_seq_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int NREG_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/regfile_access_seq_if.sv
// Bundle of the issue, writeback, operand and RegFile signals of the sequencer.
// master: the sequencer's view; slave: the surrounding pipeline/RegFile view.
interface regfile_access_seq_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          iss_valid;
   logic          iss_ready;
   logic [AW-1:0] iss_rs1;
   logic [AW-1:0] iss_rs2;
   logic [AW-1:0] iss_rd;
   logic          iss_wen;
   logic          wb_valid;
   logic          wb_ready;
   logic [AW-1:0] wb_dr;
   logic [DW-1:0] wb_data;
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [AW-1:0] op_rd;
   logic          op_wen;
   logic          EN;
   logic          RD;
   logic          WR;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [AW-1:0] DR;
   logic [DW-1:0] Data_in;
   logic [DW-1:0] BusA;
   logic [DW-1:0] BusB;
   logic          err_wb;

   modport master (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
      input  wb_valid, wb_dr, wb_data, op_ready, BusA, BusB,
      output iss_ready, wb_ready, op_valid, op_a, op_b, op_rd, op_wen,
      output EN, RD, WR, rs1, rs2, DR, Data_in, err_wb
   );

   modport slave (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
      output wb_valid, wb_dr, wb_data, op_ready, BusA, BusB,
      input  iss_ready, wb_ready, op_valid, op_a, op_b, op_rd, op_wen,
      input  EN, RD, WR, rs1, rs2, DR, Data_in, err_wb
   );
endinterface

// File: rtl/regfile_access_seq_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set on issue,
// cleared on writeback; flags a writeback to a register that was not pending.
module regfile_scoreboard
   import regfile_seq_pkg::*;
#(
   parameter int AW   = AW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] lk_a_addr,
   input  logic [AW-1:0] lk_b_addr,
   input  logic [AW-1:0] lk_c_addr,
   output logic          lk_a,
   output logic          lk_b,
   output logic          lk_c,
   output logic          err_wb
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nx;

   // Next pending vector: clear first so a same-cycle set on that register wins.
   always_comb begin
      pending_nx = pending;
      if (clr_en) pending_nx[clr_addr] = 1'b0;
      if (set_en) pending_nx[set_addr] = 1'b1;
   end

   // Pending bits and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         err_wb  <= 1'b0;
      end else begin
         pending <= pending_nx;
         if (clr_en && !pending[clr_addr]) err_wb <= 1'b1;
      end
   end

   assign lk_a = pending[lk_a_addr];
   assign lk_b = pending[lk_b_addr];
   assign lk_c = pending[lk_c_addr];

endmodule

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer: issues operand reads into RegFile, forwards
// writebacks to it, and stalls issue on RAW/WAW hazards via a scoreboard.
// Optional build macro WB_FORWARD_EN lets an issue proceed alongside a
// writeback whose register is the only source of hazard, taking wb_data directly.
module regfile_access_seq
   import regfile_seq_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int AW   = AW_DEF,
   parameter int NREG = NREG_DEF
) (
   input  logic               clk,
   input  logic               rst,
   regfile_access_seq_if.master bus
);

   state_t        state;
   state_t        state_nx;
   logic          hz_rs1;
   logic          hz_rs2;
   logic          hz_rd;
   logic          hz;
   logic          blocked;
   logic          accept;
   logic [AW-1:0] rs1_q;
   logic [AW-1:0] rs2_q;
   logic          op_valid_q;
   logic [DW-1:0] op_a_q;
   logic [DW-1:0] op_b_q;
   logic [AW-1:0] op_rd_q;
   logic          op_wen_q;
   logic [DW-1:0] cap_a;
   logic [DW-1:0] cap_b;

   regfile_scoreboard #(.AW(AW), .NREG(NREG)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_en    (accept & bus.iss_wen),
      .set_addr  (bus.iss_rd),
      .clr_en    (bus.wb_valid & ~rst),
      .clr_addr  (bus.wb_dr),
      .lk_a_addr (bus.iss_rs1),
      .lk_b_addr (bus.iss_rs2),
      .lk_c_addr (bus.iss_rd),
      .lk_a      (hz_rs1),
      .lk_b      (hz_rs2),
      .lk_c      (hz_rd),
      .err_wb    (bus.err_wb)
   );

   assign hz = hz_rs1 | hz_rs2 | (bus.iss_wen & hz_rd);

`ifdef WB_FORWARD_EN
   logic          fwd_a;
   logic          fwd_b;
   logic [DW-1:0] fwd_data;

   // A concurrent writeback only blocks issue if some hazard is on another register.
   always_comb begin
      blocked = hz;
      if (bus.wb_valid) begin
         blocked = (hz_rs1 & (bus.iss_rs1 != bus.wb_dr))
                 | (hz_rs2 & (bus.iss_rs2 != bus.wb_dr))
                 | (bus.iss_wen & hz_rd & (bus.iss_rd != bus.wb_dr));
      end
   end

   // Remember which sources bypass the RegFile read and the value they take.
   always_ff @(posedge clk) begin
      if (accept) begin
         fwd_a    <= bus.wb_valid & (bus.iss_rs1 == bus.wb_dr);
         fwd_b    <= bus.wb_valid & (bus.iss_rs2 == bus.wb_dr);
         fwd_data <= bus.wb_data;
      end
   end

   assign cap_a = fwd_a ? fwd_data : bus.BusA;
   assign cap_b = fwd_b ? fwd_data : bus.BusB;
`else
   // Writebacks own the RegFile port for the cycle, so they always block issue.
   always_comb begin
      blocked = hz | bus.wb_valid;
   end

   assign cap_a = bus.BusA;
   assign cap_b = bus.BusB;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and issue acceptance.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            accept = bus.iss_valid & ~blocked & ~rst;
            if (accept) state_nx = READ;
         end
         READ:    state_nx = HOLD;
         HOLD:    if (bus.op_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand register: tag latched at issue, data captured after the read, held until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_rd_q    <= '0;
         op_wen_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_rd_q  <= bus.iss_rd;
            op_wen_q <= bus.iss_wen;
         end
         if (state == READ) begin
            op_a_q     <= cap_a;
            op_b_q     <= cap_b;
            op_valid_q <= 1'b1;
         end else if (state == HOLD && bus.op_ready) begin
            op_valid_q <= 1'b0;
         end
      end
   end

   // Read addresses persist on the RegFile port between reads.
   always_ff @(posedge clk) begin
      if (accept) begin
         rs1_q <= bus.iss_rs1;
         rs2_q <= bus.iss_rs2;
      end
   end

   assign bus.EN        = ~rst;
   assign bus.wb_ready  = ~rst;
   assign bus.WR        = bus.wb_valid & ~rst;
   assign bus.DR        = bus.wb_dr;
   assign bus.Data_in   = bus.wb_data;
   assign bus.RD        = accept;
   assign bus.iss_ready = accept;
   assign bus.rs1       = accept ? bus.iss_rs1 : rs1_q;
   assign bus.rs2       = accept ? bus.iss_rs2 : rs2_q;
   assign bus.op_valid  = op_valid_q;
   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.op_rd     = op_rd_q;
   assign bus.op_wen    = op_wen_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench for regfile_access_seq with a behavioural RegFile model.
module tb_regfile_access_seq;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   regfile_access_seq_if #(.DW(DW), .AW(AW)) bus ();

   regfile_access_seq #(.DW(DW), .AW(AW), .NREG(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // RegFile model: registered read one cycle after RD, write on WR at the edge.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= i * 32'h0101_0101;
         mem[0] <= 32'habcd_efab;
         mem[1] <= 32'h0123_4567;
      end else begin
         if (bus.RD) begin
            bus.BusA <= mem[bus.rs1];
            bus.BusB <= mem[bus.rs2];
         end
         if (bus.WR) mem[bus.DR] <= bus.Data_in;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.iss_valid = 1'b1;
      bus.wb_valid  = 1'b1;
      bus.wb_dr     = 5'd0;
      step();
      step();
      total++; if (bus.EN !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", bus.EN); end
      total++; if (bus.RD !== 1'b0) begin bad++; $display("FAIL rst_rd got=%b want=0", bus.RD); end
      total++; if (bus.WR !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b want=0", bus.WR); end
      total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL rst_iss_ready got=%b want=0", bus.iss_ready); end
      total++; if (bus.wb_ready !== 1'b0) begin bad++; $display("FAIL rst_wb_ready got=%b want=0", bus.wb_ready); end
      total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL rst_op_valid got=%b want=0", bus.op_valid); end
      total++; if (bus.op_a !== 32'h0) begin bad++; $display("FAIL rst_op_a got=%h want=0", bus.op_a); end
      total++; if (bus.err_wb !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err_wb); end
      total++; if (dut.u_sb.pending !== 32'h0) begin bad++; $display("FAIL rst_pending got=%h want=0", dut.u_sb.pending); end
      rst = 1'b0;
      bus.iss_valid = 1'b0;
      bus.wb_valid  = 1'b0;
      #1;
      total++; if (bus.EN !== 1'b1) begin bad++; $display("FAIL run_en got=%b want=1", bus.EN); end
      total++; if (bus.wb_ready !== 1'b1) begin bad++; $display("FAIL run_wb_ready got=%b want=1", bus.wb_ready); end
      step();
   endtask

   task automatic test_issue_basic();
      bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd1; bus.iss_rd = 5'd2; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      #1;
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", bus.iss_ready); end
      total++; if (bus.RD !== 1'b1) begin bad++; $display("FAIL basic_rd got=%b want=1", bus.RD); end
      total++; if (bus.rs2 !== 5'd1) begin bad++; $display("FAIL basic_rs2 got=%0d want=1", bus.rs2); end
      step();
      bus.iss_valid = 1'b0;
      #1;
      total++; if (bus.RD !== 1'b0) begin bad++; $display("FAIL basic_rd_off got=%b want=0", bus.RD); end
      total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus.op_valid); end
      total++; if (bus.rs2 !== 5'd1) begin bad++; $display("FAIL basic_rs2_hold got=%0d want=1", bus.rs2); end
      total++; if (dut.u_sb.pending[2] !== 1'b1) begin bad++; $display("FAIL basic_pending2 got=%b want=1", dut.u_sb.pending[2]); end
      step();
      total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.op_valid); end
      total++; if (bus.op_a !== 32'habcd_efab) begin bad++; $display("FAIL basic_op_a got=%h want=abcdefab", bus.op_a); end
      total++; if (bus.op_b !== 32'h0123_4567) begin bad++; $display("FAIL basic_op_b got=%h want=01234567", bus.op_b); end
      total++; if (bus.op_rd !== 5'd2) begin bad++; $display("FAIL basic_op_rd got=%0d want=2", bus.op_rd); end
      total++; if (bus.op_wen !== 1'b1) begin bad++; $display("FAIL basic_op_wen got=%b want=1", bus.op_wen); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
      total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b want=0", bus.op_valid); end
   endtask

   task automatic test_raw_stall();
      bus.iss_rs1 = 5'd2; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd4; bus.iss_wen = 1'b0;
      bus.iss_valid = 1'b1;
      #1;
      total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b want=0", bus.iss_ready); end
      total++; if (bus.RD !== 1'b0) begin bad++; $display("FAIL raw_rd got=%b want=0", bus.RD); end
      step();
      total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL raw_stall2 got=%b want=0", bus.iss_ready); end
      bus.iss_valid = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_dr = 5'd2; bus.wb_data = 32'h5555_aaaa;
      #1;
      total++; if (bus.WR !== 1'b1) begin bad++; $display("FAIL raw_wr got=%b want=1", bus.WR); end
      total++; if (bus.DR !== 5'd2) begin bad++; $display("FAIL raw_dr got=%0d want=2", bus.DR); end
      total++; if (bus.Data_in !== 32'h5555_aaaa) begin bad++; $display("FAIL raw_data_in got=%h want=5555aaaa", bus.Data_in); end
      step();
      bus.wb_valid = 1'b0;
      bus.iss_valid = 1'b1;
      #1;
      total++; if (dut.u_sb.pending[2] !== 1'b0) begin bad++; $display("FAIL raw_clear got=%b want=0", dut.u_sb.pending[2]); end
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL raw_accept got=%b want=1", bus.iss_ready); end
      step();
      bus.iss_valid = 1'b0;
      step();
      total++; if (bus.op_a !== 32'h5555_aaaa) begin bad++; $display("FAIL raw_op_a got=%h want=5555aaaa", bus.op_a); end
      total++; if (bus.op_b !== 32'habcd_efab) begin bad++; $display("FAIL raw_op_b got=%h want=abcdefab", bus.op_b); end
      total++; if (bus.err_wb !== 1'b0) begin bad++; $display("FAIL raw_err got=%b want=0", bus.err_wb); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
   endtask

   task automatic test_hold();
      bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd1; bus.iss_rd = 5'd10; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      #1;
      step();
      bus.iss_valid = 1'b0;
      step();
      bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd13; bus.iss_wen = 1'b0;
      bus.iss_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b want=1", i, bus.op_valid); end
         total++; if (bus.op_a !== 32'habcd_efab) begin bad++; $display("FAIL hold_op_a[%0d] got=%h want=abcdefab", i, bus.op_a); end
         total++; if (bus.op_b !== 32'h0123_4567) begin bad++; $display("FAIL hold_op_b[%0d] got=%h want=01234567", i, bus.op_b); end
         total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL hold_no_issue[%0d] got=%b want=0", i, bus.iss_ready); end
         step();
      end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
      #1;
      total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", bus.op_valid); end
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL hold_next_issue got=%b want=1", bus.iss_ready); end
      step();
      bus.iss_valid = 1'b0;
      step();
      total++; if (bus.op_a !== 32'h0123_4567) begin bad++; $display("FAIL hold2_op_a got=%h want=01234567", bus.op_a); end
      total++; if (bus.op_b !== 32'habcd_efab) begin bad++; $display("FAIL hold2_op_b got=%h want=abcdefab", bus.op_b); end
      total++; if (bus.op_rd !== 5'd13) begin bad++; $display("FAIL hold2_op_rd got=%0d want=13", bus.op_rd); end
      total++; if (bus.op_wen !== 1'b0) begin bad++; $display("FAIL hold2_op_wen got=%b want=0", bus.op_wen); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
   endtask

`ifndef WB_FORWARD_EN
   task automatic test_wb_priority();
      bus.iss_rs1 = 5'd5; bus.iss_rs2 = 5'd6; bus.iss_rd = 5'd11; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      bus.wb_valid = 1'b1; bus.wb_dr = 5'd10; bus.wb_data = 32'h1111_2222;
      #1;
      total++; if (bus.WR !== 1'b1) begin bad++; $display("FAIL prio_wr got=%b want=1", bus.WR); end
      total++; if (bus.RD !== 1'b0) begin bad++; $display("FAIL prio_rd got=%b want=0", bus.RD); end
      total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b want=0", bus.iss_ready); end
      step();
      bus.wb_valid = 1'b0;
      #1;
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL prio_accept got=%b want=1", bus.iss_ready); end
      total++; if (bus.err_wb !== 1'b0) begin bad++; $display("FAIL prio_err got=%b want=0", bus.err_wb); end
      total++; if (dut.u_sb.pending[10] !== 1'b0) begin bad++; $display("FAIL prio_clear got=%b want=0", dut.u_sb.pending[10]); end
      step();
      bus.iss_valid = 1'b0;
      step();
      total++; if (bus.op_a !== 32'h0505_0505) begin bad++; $display("FAIL prio_op_a got=%h want=05050505", bus.op_a); end
      total++; if (bus.op_b !== 32'h0606_0606) begin bad++; $display("FAIL prio_op_b got=%h want=06060606", bus.op_b); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
   endtask
`else
   task automatic test_forward();
      bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd1; bus.iss_rd = 5'd3; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      #1;
      step();
      bus.iss_valid = 1'b0;
      step();
      total++; if (bus.op_a !== 32'h0123_4567) begin bad++; $display("FAIL fwd_same_src got=%h want=01234567", bus.op_a); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
      total++; if (dut.u_sb.pending[3] !== 1'b1) begin bad++; $display("FAIL fwd_pending3 got=%b want=1", dut.u_sb.pending[3]); end
      bus.iss_rs1 = 5'd3; bus.iss_rs2 = 5'd1; bus.iss_rd = 5'd12; bus.iss_wen = 1'b0;
      bus.iss_valid = 1'b1;
      bus.wb_valid = 1'b1; bus.wb_dr = 5'd3; bus.wb_data = 32'hdead_beef;
      #1;
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b want=1", bus.iss_ready); end
      total++; if (bus.RD !== 1'b1) begin bad++; $display("FAIL fwd_rd got=%b want=1", bus.RD); end
      total++; if (bus.WR !== 1'b1) begin bad++; $display("FAIL fwd_wr got=%b want=1", bus.WR); end
      step();
      bus.iss_valid = 1'b0;
      bus.wb_valid = 1'b0;
      total++; if (dut.u_sb.pending[3] !== 1'b0) begin bad++; $display("FAIL fwd_clear got=%b want=0", dut.u_sb.pending[3]); end
      step();
      total++; if (bus.op_a !== 32'hdead_beef) begin bad++; $display("FAIL fwd_op_a got=%h want=deadbeef", bus.op_a); end
      total++; if (bus.op_b !== 32'h0123_4567) begin bad++; $display("FAIL fwd_op_b got=%h want=01234567", bus.op_b); end
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
   endtask
`endif

   task automatic test_err_reset();
      total++; if (bus.err_wb !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", bus.err_wb); end
      bus.wb_valid = 1'b1; bus.wb_dr = 5'd7; bus.wb_data = 32'h7777_7777;
      step();
      bus.wb_valid = 1'b0;
      total++; if (bus.err_wb !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err_wb); end
      bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd1; bus.iss_rd = 5'd14; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      #1;
      step();
      bus.iss_valid = 1'b0;
      step();
      total++; if (bus.err_wb !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err_wb); end
      total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL err_mid_valid got=%b want=1", bus.op_valid); end
      total++; if (dut.u_sb.pending[14] !== 1'b1) begin bad++; $display("FAIL err_pending14 got=%b want=1", dut.u_sb.pending[14]); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (bus.err_wb !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.err_wb); end
      total++; if (bus.op_valid !== 1'b0) begin bad++; $display("FAIL err_drop_valid got=%b want=0", bus.op_valid); end
      total++; if (dut.u_sb.pending !== 32'h0) begin bad++; $display("FAIL err_pending got=%h want=0", dut.u_sb.pending); end
      total++; if (bus.op_a !== 32'h0) begin bad++; $display("FAIL err_op_a got=%h want=0", bus.op_a); end
      bus.iss_rs1 = 5'd14; bus.iss_rs2 = 5'd14; bus.iss_rd = 5'd14; bus.iss_wen = 1'b1;
      bus.iss_valid = 1'b1;
      #1;
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL err_issue_after got=%b want=1", bus.iss_ready); end
      step();
      bus.iss_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0; bus.iss_wen = 1'b0;
      bus.wb_valid = 1'b0; bus.wb_dr = '0; bus.wb_data = '0;
      bus.op_ready = 1'b0;
      bus.BusA = '0; bus.BusB = '0;
      test_reset();
      test_issue_basic();
      test_raw_stall();
      test_hold();
`ifndef WB_FORWARD_EN
      test_wb_priority();
`else
      test_forward();
`endif
      test_err_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
